mips_cpu_muldiv: RTL and testbench

//  Multi-cycle multiply/divide unit owning the HI/LO special registers; successor to the single-cycle ALU HI/LO path.

---
 rtl/mips_cpu_muldiv_pkg.sv | 21 ++
 rtl/mips_cpu_muldiv_if.sv | 20 ++
 rtl/mips_cpu_muldiv_div_step.sv | 21 ++
 rtl/mips_cpu_muldiv.sv | 168 ++++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: opcodes and FSM states.
package mips_cpu_muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  // State labels carry a prefix so they cannot collide with the DIV opcode.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DFIX
  } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// Request/response bundle between the control FSM (master) and the muldiv unit (slave).
interface mips_cpu_muldiv_if #(parameter int WIDTH = 32);
  import mips_cpu_muldiv_pkg::*;

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush,
                  input  busy, done, div_by_zero, hi, lo);
  modport slave  (input  start, op, a, b, flush,
                  output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv_div_step.sv
// One restoring-division step on unsigned magnitudes: shift {rem,quo} left, subtract when it fits.
module mips_cpu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < dvs on entry, so the extra top bit of diff is a clean borrow flag.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_i};
  assign rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_o   = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO.
//   state   | meaning
//   ST_IDLE | accepting start; MTHI/MTLO and divide-by-zero finish here
//   ST_MUL  | product travelling down the pipe
//   ST_DIV  | one quotient bit per cycle
//   ST_DFIX | sign correction and HI/LO write
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input logic                clk,
  input logic                rst,
  mips_cpu_muldiv_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t    state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d, dbz_q, dbz_d;
  logic [2*WIDTH-1:0]    prod_q [MUL_CYCLES];
  logic [2*WIDTH-1:0]    prod_d [MUL_CYCLES];
  logic [MUL_CYCLES-1:0] vld_q, vld_d;

  logic               mul_sgn, a_neg, b_neg;
  logic [2*WIDTH-1:0] mul_a, mul_b, mul_p;
  logic [WIDTH-1:0]   a_mag, b_mag, step_rem, step_quo;

  assign mul_sgn = (bus.op == MULT);
  assign mul_a   = {{WIDTH{mul_sgn & bus.a[WIDTH-1]}}, bus.a};
  assign mul_b   = {{WIDTH{mul_sgn & bus.b[WIDTH-1]}}, bus.b};
  assign mul_p   = mul_a * mul_b;
  assign a_neg   = (bus.op == DIV) & bus.a[WIDTH-1];
  assign b_neg   = (bus.op == DIV) & bus.b[WIDTH-1];
  assign a_mag   = a_neg ? -bus.a : bus.a;
  assign b_mag   = b_neg ? -bus.b : bus.b;

  mips_cpu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    vld_d   = '0;
    prod_d[0] = mul_p;
    for (int i = 1; i < MUL_CYCLES; i++) begin
      prod_d[i] = prod_q[i-1];
      vld_d[i]  = vld_q[i-1];
    end

    case (state_q)
      ST_IDLE: begin
        // flush outranks a simultaneous start
        if (bus.start && !bus.flush) begin
          case (bus.op)
            MTHI: begin hi_d = bus.a; done_d = 1'b1; end
            MTLO: begin lo_d = bus.a; done_d = 1'b1; end
            MULT, MULTU: begin
              state_d  = ST_MUL;
              vld_d[0] = 1'b1;
            end
            DIV, DIVU: begin
              if (bus.b == '0) begin
                done_d = 1'b1;
                dbz_d  = 1'b1;
              end else begin
                state_d = ST_DIV;
                rem_d   = '0;
                quo_d   = a_mag;
                dvs_d   = b_mag;
                qneg_d  = a_neg ^ b_neg;
                rneg_d  = a_neg;
                cnt_d   = '0;
              end
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (vld_q[MUL_CYCLES-1]) begin
          {hi_d, lo_d} = prod_q[MUL_CYCLES-1];
          state_d      = ST_IDLE;
          done_d       = 1'b1;
        end
      end
      ST_DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = ST_DFIX;
      end
      ST_DFIX: begin
        lo_d    = qneg_q ? -quo_q : quo_q;
        hi_d    = rneg_q ? -rem_q : rem_q;
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.flush && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      vld_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < MUL_CYCLES; i++) prod_q[i] <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      vld_q   <= vld_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Bench for mips_cpu_muldiv: directed table, multi-cycle corner sequences and a random run against an arithmetic model.
module tb_mips_cpu_muldiv;
  import mips_cpu_muldiv_pkg::*;

  localparam int MC0 = 2;
  localparam int MC1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_cpu_muldiv_if #(.WIDTH(32)) if0 ();
  mips_cpu_muldiv_if #(.WIDTH(16)) if1 ();

  mips_cpu_muldiv #(.WIDTH(32), .MUL_CYCLES(MC0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mips_cpu_muldiv #(.WIDTH(16), .MUL_CYCLES(MC1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t        tbl [12];
  int          n_pass = 0;
  int          n_tot  = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: actual %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Expected result computed straight from MIPS HI/LO semantics.
  task automatic model32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ehi, output logic [31:0] elo,
                         output logic edbz, output int elat);
    longint          x, y, q, r, p;
    longint unsigned pu;
    ehi = hi_m; elo = lo_m; edbz = 1'b0; elat = 0;
    case (op)
      3'd4: ehi = a;
      3'd5: elo = a;
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        ehi = p[63:32]; elo = p[31:0]; elat = MC0;
      end
      3'd1: begin
        pu = {32'h0, a} * {32'h0, b};
        ehi = pu[63:32]; elo = pu[31:0]; elat = MC0;
      end
      default: begin
        if (b == 32'h0) edbz = 1'b1;
        else begin
          elat = 33;
          if (op == 3'd2) begin
            x = longint'($signed(a)); y = longint'($signed(b));
            q = x / y; r = x % y;
            elo = q[31:0]; ehi = r[31:0];
          end else begin
            elo = a / b; ehi = a % b;
          end
        end
      end
    endcase
    hi_m = ehi; lo_m = elo;
  endtask

  task automatic drive0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if0.start = 1'b1; if0.op = muldiv_op_t'(op); if0.a = a; if0.b = b;
    @(negedge clk);
    if0.start = 1'b0;
  endtask

  // Called at the first negedge after E0; returns how many negedges it took to see done.
  task automatic wait_done0(input bit exp_busy, output int k, output bit bad);
    k = 1; bad = 1'b0;
    while (k < 100 && !if0.done) begin
      if (if0.busy !== exp_busy) bad = 1'b1;
      @(negedge clk); k++;
    end
    if (if0.busy) bad = 1'b1;
  endtask

  task automatic run0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                      input int elat, input string nm);
    int k; bit bad;
    drive0(op, a, b);
    wait_done0(elat > 0, k, bad);
    chk({nm, " latency"}, k, elat + 1);
    chk({nm, " busy"}, bad, 0);
    chk({nm, " hi"}, if0.hi, ehi);
    chk({nm, " lo"}, if0.lo, elo);
    chk({nm, " dbz"}, if0.div_by_zero, edbz);
  endtask

  task automatic run1(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] ehi, input logic [15:0] elo, input int elat,
                      input string nm, input bit b2b_start);
    int k;
    @(negedge clk);
    if1.start = 1'b1; if1.op = muldiv_op_t'(op); if1.a = a; if1.b = b;
    @(negedge clk);
    if1.start = 1'b0;
    k = 1;
    while (k < 100 && !if1.done) begin @(negedge clk); k++; end
    chk({nm, " latency"}, k, elat + 1);
    chk({nm, " hi"}, if1.hi, ehi);
    chk({nm, " lo"}, if1.lo, elo);
    if (b2b_start) begin
      if1.start = 1'b1; if1.op = MULT; if1.a = 16'd2; if1.b = 16'd3;
      @(negedge clk);
      if1.start = 1'b0;
      k = 1;
      while (k < 100 && !if1.done) begin @(negedge clk); k++; end
      chk("w16 b2b mult latency", k, MC1 + 1);
      chk("w16 b2b mult hi", if1.hi, 16'd0);
      chk("w16 b2b mult lo", if1.lo, 16'd6);
    end
  endtask

  initial begin
    int          k, ndone;
    bit          bad, nd_bad;
    logic [2:0]  rop;
    logic [31:0] ra, rb, ehi, elo;
    logic        edbz;
    int          elat;

    tbl[0]  = '{3'd4, 32'd5,          32'd0,          32'd5,          32'd0,          1'b0, 0};
    tbl[1]  = '{3'd5, 32'd9,          32'd0,          32'd5,          32'd9,          1'b0, 0};
    tbl[2]  = '{3'd2, 32'd123,        32'd0,          32'd5,          32'd9,          1'b1, 0};
    tbl[3]  = '{3'd3, 32'd55,         32'd0,          32'd5,          32'd9,          1'b1, 0};
    tbl[4]  = '{3'd0, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF,   32'hFFFFFFF1,   1'b0, MC0};
    tbl[5]  = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          1'b0, MC0};
    tbl[6]  = '{3'd2, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   1'b0, 33};
    tbl[7]  = '{3'd3, 32'd7,          32'd2,          32'd1,          32'd3,          1'b0, 33};
    tbl[8]  = '{3'd2, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 33};
    tbl[9]  = '{3'd2, 32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD,   1'b0, 33};
    tbl[10] = '{3'd3, 32'hFFFFFFFF,   32'd1,          32'd0,          32'hFFFFFFFF,   1'b0, 33};
    tbl[11] = '{3'd5, 32'd4,          32'd0,          32'd0,          32'd4,          1'b0, 0};

    if0.start = 1'b0; if0.op = MULT; if0.a = '0; if0.b = '0; if0.flush = 1'b0;
    if1.start = 1'b0; if1.op = MULT; if1.a = '0; if1.b = '0; if1.flush = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", if0.busy, 0);
    chk("reset done", if0.done, 0);
    chk("reset dbz", if0.div_by_zero, 0);
    chk("reset hi", if0.hi, 0);
    chk("reset lo", if0.lo, 0);
    chk("reset w16 hilo", {if1.hi, if1.lo}, 0);

    for (int i = 0; i < 12; i++) begin
      run0(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dbz, tbl[i].lat,
           $sformatf("vec%0d", i));
      hi_m = tbl[i].hi; lo_m = tbl[i].lo;
    end

    // Reset part-way through a divide.
    run0(3'd4, 32'h1234, 32'd0, 32'h1234, lo_m, 1'b0, 0, "pre-rst mthi");
    drive0(3'd2, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst-mid-div busy", if0.busy, 0);
    chk("rst-mid-div done", if0.done, 0);
    chk("rst-mid-div hi", if0.hi, 0);
    chk("rst-mid-div lo", if0.lo, 0);
    nd_bad = 1'b0;
    repeat (40) begin @(negedge clk); if (if0.done) nd_bad = 1'b1; end
    chk("rst-mid-div no done", nd_bad, 0);
    hi_m = '0; lo_m = '0;
    run0(3'd4, 32'd7, 32'd0, 32'd7, 32'd0, 1'b0, 0, "post-rst mthi");
    hi_m = 32'd7;

    // Flush during a divide.
    run0(3'd5, 32'hABCD, 32'd0, 32'd7, 32'hABCD, 1'b0, 0, "pre-flush mtlo");
    lo_m = 32'hABCD;
    drive0(3'd3, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    if0.flush = 1'b1;
    @(negedge clk);
    if0.flush = 1'b0;
    chk("flush busy", if0.busy, 0);
    nd_bad = if0.done;
    repeat (40) begin @(negedge clk); if (if0.done) nd_bad = 1'b1; end
    chk("flush no done", nd_bad, 0);
    chk("flush hi", if0.hi, hi_m);
    chk("flush lo", if0.lo, lo_m);

    // Start while busy is dropped; exactly one done.
    drive0(3'd0, 32'd6, 32'd7);
    if0.start = 1'b1; if0.op = MTHI; if0.a = 32'd99;
    @(negedge clk);
    if0.start = 1'b0;
    ndone = if0.done ? 1 : 0;
    repeat (10) begin @(negedge clk); if (if0.done) ndone++; end
    chk("busy-start done count", ndone, 1);
    chk("busy-start hi", if0.hi, 0);
    chk("busy-start lo", if0.lo, 42);
    hi_m = 32'd0; lo_m = 32'd42;

    // Flush beats start in IDLE, and a reserved op yields no done.
    @(negedge clk);
    if0.start = 1'b1; if0.op = MTHI; if0.a = 32'h55; if0.flush = 1'b1;
    @(negedge clk);
    if0.flush = 1'b0; if0.op = muldiv_op_t'(3'd6);
    @(negedge clk);
    if0.start = 1'b0;
    nd_bad = if0.done | if0.busy;
    repeat (5) begin @(negedge clk); if (if0.done | if0.busy) nd_bad = 1'b1; end
    chk("idle-flush/reserved no done", nd_bad, 0);
    chk("idle-flush hi", if0.hi, hi_m);

    // Back-to-back MTLO then MULT started in the done cycle.
    run0(3'd4, 32'd0, 32'd0, 32'd0, lo_m, 1'b0, 0, "b2b clear hi");
    drive0(3'd5, 32'd4, 32'd0);
    chk("b2b mtlo done", if0.done, 1);
    chk("b2b mtlo lo", if0.lo, 4);
    if0.start = 1'b1; if0.op = MULT; if0.a = 32'd2; if0.b = 32'd3;
    @(negedge clk);
    if0.start = 1'b0;
    wait_done0(1'b1, k, bad);
    chk("b2b mult latency", k, MC0 + 1);
    chk("b2b mult hi", if0.hi, 0);
    chk("b2b mult lo", if0.lo, 6);
    hi_m = 32'd0; lo_m = 32'd6;

    for (int i = 0; i < 120; i++) begin
      rop = 3'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = 32'd0; end
        1: begin ra = 32'h80000000; rb = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : $urandom; end
        2: begin ra = $urandom; rb = 32'($urandom_range(1, 20)); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      model32(rop, ra, rb, ehi, elo, edbz, elat);
      run0(rop, ra, rb, ehi, elo, edbz, elat, $sformatf("rand%0d op%0d", i, rop));
    end

    run1(3'd5, 16'd4, 16'd0, 16'd0, 16'd4, 0, "w16 mtlo", 1'b1);
    run1(3'd2, 16'hFFF9, 16'd2, 16'hFFFF, 16'hFFFD, 17, "w16 div", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
